// File: rtl/p_io_pkg.sv
// Shared types and constants for the P-series I/O port.
package p_io_pkg;

  localparam int P_IO_DATA_W = 16;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DONE,
    RD_ACK
  } rd_state_t;

endpackage

// File: rtl/p_io_out_fifo.sv
// Output word FIFO. Power-of-two depth, so the pointers wrap on their own;
// a one-bit-wider count tells full from empty.
module p_io_out_fifo
  import p_io_pkg::*;
#(
  parameter int DATA_W     = P_IO_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       count_q, count_d;
  logic              doPush, doPop;

  assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  // Head is forced to zero while empty so the line reads 0 after reset.
  assign rdata  = empty ? '0 : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata;
    end
  end

endmodule

// File: rtl/p_io_port.sv
// Device side of the P-core inputLine/outputLine pins: 4-phase input capture
// plus a FIFO-buffered output. Define P_IO_SYNC_EN to add 2-flop input synchronizers.
module p_io_port
  import p_io_pkg::*;
#(
  parameter int DATA_W     = P_IO_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              doubleClk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic [DATA_W-1:0] inputLine,
  input  logic              in_valid,
  output logic              in_ack,
  output logic [DATA_W-1:0] outputLine,
  output logic              out_valid,
  input  logic              out_ack
);

  rd_state_t         state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              inValid, outAck;
  logic              capture;
  logic              fifoFull, fifoEmpty;
  logic              push, pop;

`ifdef P_IO_SYNC_EN
  logic [1:0] inSync_q, ackSync_q;

  always_ff @(posedge doubleClk or posedge rst) begin
    if (rst) begin
      inSync_q  <= '0;
      ackSync_q <= '0;
    end else begin
      inSync_q  <= {inSync_q[0], in_valid};
      ackSync_q <= {ackSync_q[0], out_ack};
    end
  end

  assign inValid = inSync_q[1];
  assign outAck  = ackSync_q[1];
`else
  assign inValid = in_valid;
  assign outAck  = out_ack;
`endif

  always_ff @(posedge doubleClk or posedge rst) begin
    if (rst) begin
      state_q <= RD_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // RD_DONE is the single cycle in which the core sees its read complete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (cpu_rd)  state_d = RD_WAIT;
      RD_WAIT: if (inValid) state_d = RD_DONE;
      RD_DONE: state_d = inValid ? RD_ACK : RD_IDLE;
      RD_ACK:  if (!inValid) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    capture   = (state_q == RD_WAIT) && inValid;
    rdata_d   = capture ? inputLine : rdata_q;
    in_ack    = (state_q == RD_DONE) || (state_q == RD_ACK);
    cpu_stall = (cpu_rd && (state_q != RD_DONE)) || (cpu_wr && !cpu_rd && fifoFull);
    if (rst) begin
      cpu_stall = cpu_rd || cpu_wr;
    end
  end

  // A simultaneous read takes priority, so the write neither pushes nor sees FIFO state.
  assign push      = cpu_wr && !cpu_rd && !fifoFull;
  assign pop       = out_valid && outAck;
  assign out_valid = !fifoEmpty;
  assign cpu_rdata = rdata_q;

  p_io_out_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk  (doubleClk),
    .rst  (rst),
    .push (push),
    .wdata(cpu_wdata),
    .pop  (pop),
    .rdata(outputLine),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

endmodule

// File: tb/tb_p_io_port.sv
// Scoreboard bench for p_io_port (default build, P_IO_SYNC_EN undefined).
module tb_p_io_port;
  import p_io_pkg::*;

  localparam int DW = 16;

  logic          doubleClk = 1'b0;
  logic          rst       = 1'b1;
  logic          cpu_rd    = 1'b0;
  logic          cpu_wr    = 1'b0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] inputLine = '0;
  logic          in_valid  = 1'b0;
  logic          out_ack   = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          in_ack;
  logic [DW-1:0] outputLine;
  logic          out_valid;

  int vecCount  = 0;
  int missCount = 0;
  logic [DW-1:0] wrQ[$];
  logic [DW-1:0] rdQ[$];

  p_io_port #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .doubleClk (doubleClk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .inputLine (inputLine),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .outputLine(outputLine),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  always #5 doubleClk = ~doubleClk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic flagError(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic nextCycle();
    @(posedge doubleClk);
    #1;
  endtask

  // Issues a CPU request, holds it until a non-stall cycle, and returns the stall count.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [DW-1:0] data,
                               output int stalls);
    bit done;
    done      = 1'b0;
    stalls    = 0;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = data;
    if (wr && !rd) wrQ.push_back(data);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge doubleClk);
      if (!cpu_stall) done = 1'b1;
      else begin
        stalls++;
        nextCycle();
      end
    end
    if (!done) flagError("cpu request timeout");
    nextCycle();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Monitor: compares every transferred word and every completed read against the queues.
  initial begin
    forever begin
      @(negedge doubleClk);
      if (!rst && out_valid && out_ack) begin
        if (wrQ.size() == 0) flagError("pop with no expected word");
        else checkOutput("outputLine", 32'(outputLine), 32'(wrQ.pop_front()));
      end
      if (!rst && cpu_rd && !cpu_stall) begin
        if (rdQ.size() == 0) flagError("read with no expected word");
        else checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(rdQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int st;
    bit drained;

    // Reset values
    @(negedge doubleClk);
    @(negedge doubleClk);
    checkOutput("rst cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("rst outputLine", 32'(outputLine), 0);
    checkOutput("rst out_valid", 32'(out_valid), 0);
    checkOutput("rst in_ack", 32'(in_ack), 0);
    checkOutput("rst cpu_stall idle", 32'(cpu_stall), 0);
    cpu_wr = 1'b1;
    #1;
    checkOutput("rst cpu_stall on wr", 32'(cpu_stall), 1);
    cpu_wr = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // IN, best case
    in_valid  = 1'b1;
    inputLine = 16'd4;
    rdQ.push_back(16'd4);
    applyStimulus(1'b1, 1'b0, '0, st);
    checkOutput("read stall cycles", 32'(st), 2);
    @(negedge doubleClk);
    checkOutput("in_ack held", 32'(in_ack), 1);
    nextCycle();
    nextCycle();
    in_valid = 1'b0;
    @(negedge doubleClk);
    checkOutput("in_ack before clear", 32'(in_ack), 1);
    nextCycle();
    @(negedge doubleClk);
    checkOutput("in_ack cleared", 32'(in_ack), 0);
    nextCycle();

    // Single OUT and pop
    applyStimulus(1'b0, 1'b1, 16'd35, st);
    checkOutput("write stall", 32'(st), 0);
    @(negedge doubleClk);
    checkOutput("out_valid after write", 32'(out_valid), 1);
    checkOutput("outputLine after write", 32'(outputLine), 35);
    nextCycle();
    out_ack = 1'b1;
    nextCycle();
    out_ack = 1'b0;
    @(negedge doubleClk);
    checkOutput("out_valid after pop", 32'(out_valid), 0);
    nextCycle();

    // Fill the FIFO, fifth write stalls until one pop
    applyStimulus(1'b0, 1'b1, 16'd765, st);
    checkOutput("fill stall 1", 32'(st), 0);
    applyStimulus(1'b0, 1'b1, 16'd2345, st);
    checkOutput("fill stall 2", 32'(st), 0);
    applyStimulus(1'b0, 1'b1, 16'd1, st);
    checkOutput("fill stall 3", 32'(st), 0);
    applyStimulus(1'b0, 1'b1, 16'd2, st);
    checkOutput("fill stall 4", 32'(st), 0);
    fork
      applyStimulus(1'b0, 1'b1, 16'd3, st);
      begin
        repeat (3) nextCycle();
        out_ack = 1'b1;
        nextCycle();
        out_ack = 1'b0;
      end
    join
    checkOutput("full write stall", 32'(st), 4);
    out_ack = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 20 && !drained; k++) begin
      @(negedge doubleClk);
      if (!out_valid) drained = 1'b1;
      else nextCycle();
    end
    nextCycle();
    out_ack = 1'b0;
    checkOutput("drain completes", 32'(drained), 1);

    // Simultaneous push and pop with one word held
    applyStimulus(1'b0, 1'b1, 16'd9, st);
    checkOutput("single word stall", 32'(st), 0);
    cpu_wr    = 1'b1;
    cpu_wdata = 16'd7;
    out_ack   = 1'b1;
    wrQ.push_back(16'd7);
    @(negedge doubleClk);
    checkOutput("push+pop stall", 32'(cpu_stall), 0);
    nextCycle();
    cpu_wr  = 1'b0;
    out_ack = 1'b0;
    @(negedge doubleClk);
    checkOutput("push+pop out_valid", 32'(out_valid), 1);
    checkOutput("push+pop outputLine", 32'(outputLine), 7);
    nextCycle();
    out_ack = 1'b1;
    nextCycle();
    out_ack = 1'b0;
    @(negedge doubleClk);
    checkOutput("push+pop count was 1", 32'(out_valid), 0);
    nextCycle();

    // Read and write together: read wins, nothing is pushed
    in_valid  = 1'b1;
    inputLine = 16'h0055;
    rdQ.push_back(16'h0055);
    applyStimulus(1'b1, 1'b1, 16'd99, st);
    checkOutput("rd+wr stall cycles", 32'(st), 2);
    @(negedge doubleClk);
    checkOutput("rd+wr no push", 32'(out_valid), 0);
    nextCycle();
    in_valid = 1'b0;
    nextCycle();
    nextCycle();

    // Asynchronous reset while in RD_WAIT
    cpu_rd = 1'b1;
    nextCycle();
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid-reset in_ack", 32'(in_ack), 0);
    checkOutput("mid-reset state", 32'(dut.state_q), 32'(RD_IDLE));
    checkOutput("mid-reset cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("mid-reset cpu_stall", 32'(cpu_stall), 1);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    @(negedge doubleClk);
    checkOutput("re-enter RD_WAIT", 32'(dut.state_q), 32'(RD_WAIT));
    nextCycle();
    in_valid  = 1'b1;
    inputLine = 16'h1234;
    rdQ.push_back(16'h1234);
    applyStimulus(1'b1, 1'b0, '0, st);
    checkOutput("post-reset read stall", 32'(st), 1);
    in_valid = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("final in_ack", 32'(in_ack), 0);

    checkOutput("wr scoreboard empty", 32'(wrQ.size()), 0);
    checkOutput("rd scoreboard empty", 32'(rdQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
